bsg_mem_1rw_sync_mask_write_byte_banked: RTL and testbench



---
 rtl/bsg_mem_1rw_sync_mask_write_byte_banked.sv | 249 ++++++++++++++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_byte_banked.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_banked.sv
// ---------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_byte_banked
//
// Single-port, byte-masked synchronous memory assembled from a grid of
// 512 x 64 hard byte-mask SRAM macros: banks tile the depth, slices tile
// the width. On top of the raw macros it adds a post-reset zero-fill
// sweep, a read-valid pulse and a read-data hold register so data_o stays
// stable between reads.
//
// Ports
//   clk_i         single clock, all state on the rising edge
//   reset_n_i     asynchronous active-low reset
//   v_i           request valid (taken only while ready_o=1)
//   w_i           1 = write, 0 = read
//   addr_i        word address; upper bits pick the bank, low 9 bits the row
//   data_i        write data
//   write_mask_i  per-byte write enable, bit b covers data bits [8b+7:8b]
//   ready_o       high once the block accepts requests
//   v_o           one-cycle pulse, the cycle after an accepted read
//   data_o        read data, held until the next accepted read
//
// Also contains bsg_mem_1rw_sync_mask_write_byte_macro, the behavioural
// stand-in for the 512 x 64 hard macro.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_byte_macro
//
// Behavioural model of one hard byte-mask SRAM macro.
//
// Ports
//   clk_i         clock
//   reset_i       active-high reset, clears only the read-data register
//   v_i           access enable
//   w_i           1 = write, 0 = read
//   addr_i        row address
//   data_i        write data
//   write_mask_i  per-byte write enable
//   data_o        registered read data
// ---------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_byte_macro #(
   parameter int els_p   = 512,
   parameter int width_p = 64
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       v_i,
   input  logic                       w_i,
   input  logic [$clog2(els_p)-1:0]   addr_i,
   input  logic [width_p-1:0]         data_i,
   input  logic [width_p/8-1:0]       write_mask_i,
   output logic [width_p-1:0]         data_o
);

   logic [width_p-1:0] mem_r [els_p];
   logic [width_p-1:0] data_r;

   // Storage array carries no reset, exactly like a real SRAM; only the
   // enabled bytes of the addressed row are updated.
   always_ff @(posedge clk_i) begin
      if (v_i && w_i) begin
         for (int b = 0; b < width_p/8; b++) begin
            if (write_mask_i[b]) begin
               mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
            end
         end
      end
   end

   // Synchronous read port: the row appears on data_o the cycle after the
   // read is enabled and stays until the next read.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_r <= '0;
      end else if (v_i && !w_i) begin
         data_r <= mem_r[addr_i];
      end
   end

   assign data_o = data_r;

endmodule


module bsg_mem_1rw_sync_mask_write_byte_banked #(
   parameter int els_p         = 2048,
   parameter int data_width_p  = 128,
   parameter int macro_els_p   = 512,
   parameter int macro_width_p = 64,
   parameter int init_p        = 1
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       v_i,
   input  logic                       w_i,
   input  logic [$clog2(els_p)-1:0]   addr_i,
   input  logic [data_width_p-1:0]    data_i,
   input  logic [data_width_p/8-1:0]  write_mask_i,
   output logic                       ready_o,
   output logic                       v_o,
   output logic [data_width_p-1:0]    data_o
);

   localparam int addr_width_lp  = $clog2(els_p);
   localparam int row_width_lp   = $clog2(macro_els_p);
   localparam int banks_lp       = els_p / macro_els_p;
   localparam int slices_lp      = data_width_p / macro_width_p;
   localparam int bank_width_lp  = (banks_lp > 1) ? $clog2(banks_lp) : 1;
   localparam int slice_mask_lp  = macro_width_p / 8;
   localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(macro_els_p - 1);

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_e;

   state_e                     state_r, state_n;
   logic [row_width_lp-1:0]    row_r, row_n;

   logic                       sweeping;
   logic                       accept;
   logic                       accept_rd;
   logic                       macro_reset;
   logic [bank_width_lp-1:0]   bank_sel;
   logic [row_width_lp-1:0]    row_sel;

   logic                       rd_pend_r;
   logic [bank_width_lp-1:0]   bank_r;
   logic [data_width_p-1:0]    hold_r;
   logic [data_width_p-1:0]    rd_data;
   logic [data_width_p-1:0]    bank_data [banks_lp];

   // -----------------------------------------------------------------------
   // Request decode
   // -----------------------------------------------------------------------
   assign sweeping    = (state_r == INIT);
   assign ready_o     = (state_r == IDLE);
   assign accept      = v_i & ready_o;
   assign accept_rd   = accept & ~w_i;
   assign macro_reset = ~reset_n_i;
   assign row_sel     = addr_i[row_width_lp-1:0];

   // With a single bank there are no bank bits in the address and the
   // read mux collapses to a wire.
   if (banks_lp > 1) begin : g_multi_bank
      assign bank_sel = addr_i[addr_width_lp-1:row_width_lp];
      assign rd_data  = bank_data[bank_r];
   end else begin : g_single_bank
      assign bank_sel = '0;
      assign rd_data  = bank_data[0];
   end

   // -----------------------------------------------------------------------
   // Sweep FSM: INIT walks every row once, writing zeros to all banks and
   // slices in parallel, then parks in IDLE for normal service.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= (init_p != 0) ? INIT : IDLE;
         row_r   <= '0;
      end else begin
         state_r <= state_n;
         row_r   <= row_n;
      end
   end

   always_comb begin
      state_n = state_r;
      row_n   = row_r;
      case (state_r)
         INIT: begin
            row_n = row_r + row_width_lp'(1);
            if (row_r == last_row_lp) begin
               state_n = IDLE;
            end
         end
         IDLE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Macro array. Every bank sees the sweep; outside the sweep only the
   // addressed bank is enabled so idle banks never toggle.
   // -----------------------------------------------------------------------
   for (genvar b = 0; b < banks_lp; b++) begin : g_bank
      logic                      bank_v;
      logic                      bank_w;
      logic [row_width_lp-1:0]   bank_addr;
      logic [data_width_p-1:0]   bank_q;

      assign bank_v    = sweeping | (accept & (bank_sel == bank_width_lp'(b)));
      assign bank_w    = sweeping | w_i;
      assign bank_addr = sweeping ? row_r : row_sel;
      assign bank_data[b] = bank_q;

      for (genvar s = 0; s < slices_lp; s++) begin : g_slice
         logic [macro_width_p-1:0]  slice_data;
         logic [slice_mask_lp-1:0]  slice_mask;

         assign slice_data = sweeping ? '0 : data_i[s*macro_width_p +: macro_width_p];
         assign slice_mask = sweeping ? '1 : write_mask_i[s*slice_mask_lp +: slice_mask_lp];

         bsg_mem_1rw_sync_mask_write_byte_macro #(
            .els_p   (macro_els_p),
            .width_p (macro_width_p)
         ) macro (
            .clk_i        (clk_i),
            .reset_i      (macro_reset),
            .v_i          (bank_v),
            .w_i          (bank_w),
            .addr_i       (bank_addr),
            .data_i       (slice_data),
            .write_mask_i (slice_mask),
            .data_o       (bank_q[s*macro_width_p +: macro_width_p])
         );
      end
   end

   // -----------------------------------------------------------------------
   // Read return path. The bank index is remembered so the cycle after a
   // read can steer the right macro outputs to data_o; the hold register
   // then keeps that value because the macros' own outputs are not
   // guaranteed to be stable once another bank or row is read.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_pend_r <= 1'b0;
         bank_r    <= '0;
         hold_r    <= '0;
      end else begin
         rd_pend_r <= accept_rd;
         if (accept_rd) begin
            bank_r <= bank_sel;
         end
         if (rd_pend_r) begin
            hold_r <= rd_data;
         end
      end
   end

   assign v_o    = rd_pend_r;
   assign data_o = rd_pend_r ? rd_data : hold_r;

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_banked.sv
// ---------------------------------------------------------------------------
// tb_bsg_mem_1rw_sync_mask_write_byte_banked
//
// Self-checking bench for the banked byte-mask memory. A word-array model
// with per-byte updates predicts read data; a second instance with the
// sweep disabled covers the init_p=0 configuration.
// ---------------------------------------------------------------------------
module tb_bsg_mem_1rw_sync_mask_write_byte_banked;

   localparam int ELS = 2048;
   localparam int DW  = 128;
   localparam int MW  = DW / 8;
   localparam int AW  = 11;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n = 1'b0;
   logic          v = 1'b0;
   logic          w = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data = '0;
   logic [MW-1:0] mask = '0;
   logic          ready;
   logic          v_o;
   logic [DW-1:0] data_o;

   logic          z_reset_n = 1'b0;
   logic          z_v = 1'b0;
   logic          z_w = 1'b0;
   logic [AW-1:0] z_addr = '0;
   logic [DW-1:0] z_data = '0;
   logic [MW-1:0] z_mask = '0;
   logic          z_ready;
   logic          z_v_o;
   logic [DW-1:0] z_data_o;

   bsg_mem_1rw_sync_mask_write_byte_banked #(
      .els_p(ELS), .data_width_p(DW), .macro_els_p(512), .macro_width_p(64), .init_p(1)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .addr_i(addr),
      .data_i(data), .write_mask_i(mask), .ready_o(ready), .v_o(v_o), .data_o(data_o)
   );

   bsg_mem_1rw_sync_mask_write_byte_banked #(
      .els_p(ELS), .data_width_p(DW), .macro_els_p(512), .macro_width_p(64), .init_p(0)
   ) dut_noinit (
      .clk_i(clk), .reset_n_i(z_reset_n), .v_i(z_v), .w_i(z_w), .addr_i(z_addr),
      .data_i(z_data), .write_mask_i(z_mask), .ready_o(z_ready), .v_o(z_v_o), .data_o(z_data_o)
   );

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] model [ELS];
   logic [DW-1:0] exp_hold = '0;

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit vv, input bit ww, input int a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
      v    = vv;
      w    = ww;
      addr = AW'(a);
      data = d;
      mask = m;
   endtask

   function automatic void model_write(input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      for (int b = 0; b < MW; b++) begin
         if (m[b]) model[a][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < ELS; i++) model[i] = '0;
   endfunction

   function automatic logic [DW-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, '0, '0);
      step();
      step();
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
      vectors++;
      if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_v_o: got %b expected 0", v_o); end
      vectors++;
      if (data_o !== '0) begin miscompares++; $display("[TB] FAIL reset_data_o: got %h expected 0", data_o); end
   endtask

   // Releases reset, then counts edges until ready rises. Optionally
   // pokes a read at sweep cycle 10 which must be ignored.
   task automatic test_init_sweep(input bit probe_ignored);
      reset_n = 1'b1;
      for (int k = 1; k <= 512; k++) begin
         drive(probe_ignored && (k == 10), 0, 0, '0, '1);
         step();
         vectors++;
         if (ready !== (k == 512)) begin
            miscompares++;
            $display("[TB] FAIL sweep_ready k=%0d: got %b expected %b", k, ready, (k == 512));
         end
         vectors++;
         if (v_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sweep_v_o k=%0d: got %b expected 0", k, v_o);
         end
      end
      drive(0, 0, 0, '0, '0);
      model_clear();
      exp_hold = '0;
   endtask

   task automatic test_sweep_reads();
      int addrs [4] = '{0, 511, 1536, 2047};
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, addrs[i], rand_word(), '0);
         step();
         vectors++;
         if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_read_v addr=%0d: got %b expected 1", addrs[i], v_o); end
         vectors++;
         if (data_o !== model[addrs[i]]) begin
            miscompares++;
            $display("[TB] FAIL zero_read_data addr=%0d: got %h expected %h", addrs[i], data_o, model[addrs[i]]);
         end
         exp_hold = model[addrs[i]];
      end
      drive(0, 0, 0, '0, '0);
      step();
      vectors++;
      if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_read_v_drop: got %b expected 0", v_o); end
   endtask

   task automatic test_byte_mask();
      drive(1, 1, 600, 128'hFFEEDDCCBBAA99887766554433221100, 16'hFFFF);
      step();
      model_write(600, data, mask);
      vectors++;
      if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_write_v: got %b expected 0", v_o); end
      drive(1, 1, 600, '0, 16'h00F0);
      step();
      model_write(600, data, mask);
      drive(1, 0, 600, '0, '0);
      step();
      vectors++;
      if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mask_read_v: got %b expected 1", v_o); end
      vectors++;
      if (data_o !== 128'hFFEEDDCCBBAA99880000000033221100) begin
         miscompares++;
         $display("[TB] FAIL mask_read_data: got %h expected %h", data_o, 128'hFFEEDDCCBBAA99880000000033221100);
      end
      vectors++;
      if (data_o !== model[600]) begin miscompares++; $display("[TB] FAIL mask_model_data: got %h expected %h", data_o, model[600]); end
      drive(1, 0, 88, '0, '0);
      step();
      vectors++;
      if (data_o !== model[88]) begin miscompares++; $display("[TB] FAIL other_bank_data: got %h expected %h", data_o, model[88]); end
      exp_hold = model[88];
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_hold();
      logic [DW-1:0] saved;
      drive(1, 0, 600, '0, '0);
      step();
      saved = model[600];
      vectors++;
      if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_read_v: got %b expected 1", v_o); end
      vectors++;
      if (data_o !== saved) begin miscompares++; $display("[TB] FAIL hold_read_data: got %h expected %h", data_o, saved); end
      drive(1, 1, 600, rand_word(), '1);
      step();
      model_write(600, data, mask);
      drive(0, 0, 0, '0, '0);
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_v i=%0d: got %b expected 0", i, v_o); end
         vectors++;
         if (data_o !== saved) begin miscompares++; $display("[TB] FAIL hold_data i=%0d: got %h expected %h", i, data_o, saved); end
         step();
      end
      exp_hold = saved;
   endtask

   task automatic test_back_to_back();
      int addrs [4] = '{5, 517, 1029, 1541};
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, addrs[i], DW'(i + 1), '1);
         step();
         model_write(addrs[i], data, mask);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, addrs[i], '0, '0);
         step();
         vectors++;
         if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_v i=%0d: got %b expected 1", i, v_o); end
         vectors++;
         if (data_o !== model[addrs[i]]) begin
            miscompares++;
            $display("[TB] FAIL b2b_data i=%0d: got %h expected %h", i, data_o, model[addrs[i]]);
         end
         exp_hold = model[addrs[i]];
      end
      drive(0, 0, 0, '0, '0);
      step();
      vectors++;
      if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_v_drop: got %b expected 0", v_o); end
      vectors++;
      if (data_o !== exp_hold) begin miscompares++; $display("[TB] FAIL b2b_hold: got %h expected %h", data_o, exp_hold); end
   endtask

   // Random mix over a few rows of every bank so writes and reads collide.
   task automatic test_random(input int n);
      bit            pend;
      logic [DW-1:0] pend_val;
      logic [DW-1:0] exp_data;
      int            a;
      for (int i = 0; i < n; i++) begin
         a = int'($urandom_range(0, 3)) * 512 + int'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, a, rand_word(), MW'($urandom()));
         pend     = v && !w;
         pend_val = model[a];
         step();
         if (v && w) model_write(a, data, mask);
         exp_data = pend ? pend_val : exp_hold;
         vectors++;
         if (v_o !== pend) begin miscompares++; $display("[TB] FAIL rand_v i=%0d: got %b expected %b", i, v_o, pend); end
         vectors++;
         if (data_o !== exp_data) begin
            miscompares++;
            $display("[TB] FAIL rand_data i=%0d addr=%0d: got %h expected %h", i, a, data_o, exp_data);
         end
         if (pend) exp_hold = pend_val;
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_reset_mid_sweep();
      drive(1, 0, 600, '0, '0);
      step();
      vectors++;
      if (v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midread_v: got %b expected 1", v_o); end
      drive(0, 0, 0, '0, '0);
      reset_n = 1'b0;
      #1;
      vectors++;
      if (v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midread_abort_v: got %b expected 0", v_o); end
      vectors++;
      if (data_o !== '0) begin miscompares++; $display("[TB] FAIL midread_abort_data: got %h expected 0", data_o); end
      vectors++;
      if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midread_abort_ready: got %b expected 0", ready); end
      step();
      step();
      reset_n = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         vectors++;
         if (ready !== 1'b0 || v_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL partial_sweep k=%0d: got ready=%b v_o=%b expected 0 0", k, ready, v_o);
         end
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b0 || v_o !== 1'b0 || data_o !== '0) begin
         miscompares++;
         $display("[TB] FAIL midsweep_reset: got ready=%b v_o=%b data=%h expected 0 0 0", ready, v_o, data_o);
      end
      step();
      step();
      test_init_sweep(1'b0);
   endtask

   task automatic test_init_p0();
      logic [DW-1:0] word;
      z_reset_n = 1'b0;
      #1;
      vectors++;
      if (z_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL noinit_reset_ready: got %b expected 1", z_ready); end
      step();
      z_reset_n = 1'b1;
      step();
      vectors++;
      if (z_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL noinit_ready: got %b expected 1", z_ready); end
      word   = rand_word();
      z_v    = 1'b1;
      z_w    = 1'b1;
      z_addr = AW'(1234);
      z_data = word;
      z_mask = '1;
      step();
      vectors++;
      if (z_v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL noinit_write_v: got %b expected 0", z_v_o); end
      z_w    = 1'b0;
      z_data = '0;
      step();
      z_v = 1'b0;
      vectors++;
      if (z_v_o !== 1'b1) begin miscompares++; $display("[TB] FAIL noinit_read_v: got %b expected 1", z_v_o); end
      vectors++;
      if (z_data_o !== word) begin miscompares++; $display("[TB] FAIL noinit_read_data: got %h expected %h", z_data_o, word); end
   endtask

   initial begin
      $display("[TB] start");
      test_reset();
      test_init_sweep(1'b1);
      test_sweep_reads();
      test_byte_mask();
      test_hold();
      test_back_to_back();
      test_random(400);
      test_reset_mid_sweep();
      test_sweep_reads();
      test_random(200);
      test_init_p0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
